// File: rtl/mem8x8_pkg.sv
// Shared types and constants for the 8x8 byte-cell array access controller.
package mem8x8_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic       we;
    logic [2:0] addr;
    logic [7:0] wdata;
  } req_t;

  localparam logic       OP_WRITE  = 1'b0;
  localparam logic       OP_READ   = 1'b1;
  localparam logic [7:0] IDLE_INP  = 8'h00;
  localparam logic [7:0] IDLE_INPN = 8'hFF;

endpackage

// File: rtl/mem8x8_addr_dec.sv
// 3-to-8 one-hot byte-select decoder; all zeros when disabled.
module mem8x8_addr_dec (
  input  logic       en,
  input  logic [2:0] addr,
  output logic [7:0] sel
);

  always_comb begin
    sel = '0;
    if (en) sel[addr] = 1'b1;
  end

endmodule

// File: rtl/mem8x8_access_ctrl.sv
// Sequences single read/write accesses to the 8x8 array through SETUP/STROBE/HOLD.
// Optional MEM8X8_READBACK_VERIFY_EN adds a read-back pass after each write.
module mem8x8_access_ctrl
  import mem8x8_pkg::*;
#(
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [2:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic [7:0] mem_inp,
  output logic [7:0] mem_inpn,
  output logic       mem_op,
  output logic [7:0] mem_sel,
  input  logic [7:0] mem_outp
);

  localparam int CNT_MAX = (STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

`ifdef MEM8X8_READBACK_VERIFY_EN
  localparam logic VERIFY = 1'b1;
`else
  localparam logic VERIFY = 1'b0;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  req_t             req_q, req_n;
  logic             vpass_q, vpass_n;
  logic [7:0]       samp_q;

  logic             rd_n;
  logic             op_d;
  logic [7:0]       inp_d;
  logic             sel_en;
  logic [7:0]       sel_d;

  // Request fields are taken straight from the ports on the accept edge so the
  // SETUP-cycle outputs can already be registered with the new values.
  always_comb begin
    req_n = req_q;
    if (state_q == ST_IDLE) req_n = '{we: req_we, addr: req_addr, wdata: req_wdata};
  end

  always_comb begin
    vpass_n = vpass_q;
    if (state_q == ST_IDLE) vpass_n = 1'b0;
    else if (state_q == ST_HOLD && state_d == ST_SETUP) vpass_n = 1'b1;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_valid) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_STROBE;
      ST_STROBE: if (cnt_q == STROBE_LAST) state_d = ST_HOLD;
      ST_HOLD:   if (cnt_q == HOLD_LAST)
                   state_d = (VERIFY && req_q.we && !vpass_q) ? ST_SETUP : ST_RESP;
      ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output logic: array-side values for the upcoming state, registered below
  always_comb begin
    rd_n   = !req_n.we || vpass_n;
    op_d   = OP_READ;
    inp_d  = IDLE_INP;
    sel_en = (state_d == ST_STROBE);
    if (state_d == ST_SETUP || state_d == ST_STROBE || state_d == ST_HOLD) begin
      op_d  = rd_n ? OP_READ : OP_WRITE;
      inp_d = rd_n ? IDLE_INP : req_n.wdata;
    end
  end

  mem8x8_addr_dec u_dec (
    .en   (sel_en),
    .addr (req_n.addr),
    .sel  (sel_d)
  );

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      req_q     <= '0;
      vpass_q   <= 1'b0;
      samp_q    <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_inp   <= IDLE_INP;
      mem_inpn  <= IDLE_INPN;
      mem_op    <= OP_READ;
      mem_sel   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_n;
      vpass_q <= vpass_n;
      if (state_d != state_q) cnt_q <= '0;
      else if (state_q == ST_STROBE || state_q == ST_HOLD) cnt_q <= cnt_q + 1'b1;

      if (state_q == ST_STROBE && cnt_q == STROBE_LAST && mem_op == OP_READ)
        samp_q <= mem_outp;

      if (state_d == ST_RESP && state_q != ST_RESP) begin
        rsp_rdata <= (!req_q.we || VERIFY) ? samp_q : 8'h00;
        rsp_err   <= VERIFY && req_q.we && (samp_q != req_q.wdata);
      end

      req_ready <= (state_d == ST_IDLE);
      rsp_valid <= (state_d == ST_RESP);
      mem_op    <= op_d;
      mem_inp   <= inp_d;
      mem_inpn  <= ~inp_d;
      mem_sel   <= sel_d;
    end
  end

endmodule

// File: tb/tb_mem8x8_access_ctrl.sv
// Directed bench for mem8x8_access_ctrl with a small behavioural 8x8 array model.
module tb_mem8x8_access_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_we;
  logic [2:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [7:0] rsp_rdata;
  logic [7:0] mem_inp, mem_inpn, mem_sel, mem_outp;
  logic       mem_op;

  int n_chk  = 0;
  int n_pass = 0;

`ifdef MEM8X8_READBACK_VERIFY_EN
  localparam bit VFY = 1'b1;
`else
  localparam bit VFY = 1'b0;
`endif

  mem8x8_access_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_inp   (mem_inp),
    .mem_inpn  (mem_inpn),
    .mem_op    (mem_op),
    .mem_sel   (mem_sel),
    .mem_outp  (mem_outp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Array model: stores on write strobes, drives the selected byte on the bus.
  logic [7:0] mem [8] = '{default: 8'h00};
  logic       corrupt = 1'b0;

  always_comb begin
    mem_outp = 8'h00;
    for (int i = 0; i < 8; i++)
      if (mem_sel[i]) mem_outp = mem[i] ^ {7'b0, corrupt};
  end

  always @(posedge clk)
    if (mem_op == 1'b0)
      for (int i = 0; i < 8; i++)
        if (mem_sel[i]) mem[i] <= mem_inp;

  // Array-side invariants, every cycle out of reset
  logic [8:0] prev_ctl = '0;
  logic       prev_act = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      chk("inpn_cpl", {24'h0, mem_inpn ^ mem_inp}, 32'hFF);
      chk("sel_onehot0", ($countones(mem_sel) <= 1), 1);
      if (prev_act && mem_sel != 8'h00) chk("ctl_stable", {23'h0, mem_op, mem_inp}, {23'h0, prev_ctl});
    end
    prev_act = (mem_sel != 8'h00);
    prev_ctl = {mem_op, mem_inp};
  end

  task automatic access(input logic we, input logic [2:0] a, input logic [7:0] d, input int bp,
                        input int exp_lat, input logic [7:0] exp_rd, input logic exp_err);
    int         lat, selc;
    logic [7:0] inp1, inpn1, sel1, exp_inp, exp_inpn, exp_sel;
    logic       op1;
    exp_inp  = we ? d : 8'h00;
    exp_inpn = ~exp_inp;
    exp_sel  = 8'h01 << a;
    req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1; rsp_ready = (bp == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    inp1 = mem_inp; inpn1 = mem_inpn; op1 = mem_op; sel1 = mem_sel;
    lat = 0; selc = 0;
    for (int c = 1; c <= 40; c++) begin
      if (mem_sel == exp_sel) selc++;
      if (rsp_valid) begin lat = c; break; end
      @(posedge clk); #1;
    end
    chk("setup_inp", inp1, exp_inp);
    chk("setup_inpn", inpn1, exp_inpn);
    chk("setup_op", op1, !we);
    chk("setup_sel", sel1, 0);
    chk("strobe_cycles", selc, (we && VFY) ? 4 : 2);
    chk("latency", lat, exp_lat);
    chk("rdata", rsp_rdata, exp_rd);
    chk("err", rsp_err, exp_err);
    for (int k = 0; k < bp; k++) begin
      @(posedge clk); #1;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_rdata", rsp_rdata, exp_rd);
      chk("bp_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("back_idle", req_ready, 1);
    chk("rsp_clear", rsp_valid, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_sel"}, mem_sel, 8'h00);
    chk({tag, "_inp"}, mem_inp, 8'h00);
    chk({tag, "_inpn"}, mem_inpn, 8'hFF);
    chk({tag, "_op"}, mem_op, 1);
  endtask

  initial begin
    logic seen;
    int   wlat;
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd1; req_wdata = 8'h3C; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst = 1'b0; req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_no_accept", rsp_valid | (mem_sel != 0), 0);

    wlat = VFY ? 9 : 5;
    access(1'b1, 3'd5, 8'hAA, 0, wlat, VFY ? 8'hAA : 8'h00, 1'b0);
    access(1'b0, 3'd5, 8'h00, 0, 5, 8'hAA, 1'b0);
    access(1'b1, 3'd2, 8'hCC, 0, wlat, VFY ? 8'hCC : 8'h00, 1'b0);
    access(1'b0, 3'd2, 8'h00, 4, 5, 8'hCC, 1'b0);
    access(1'b1, 3'd0, 8'h00, 0, wlat, 8'h00, 1'b0);
    access(1'b1, 3'd7, 8'hFF, 0, wlat, VFY ? 8'hFF : 8'h00, 1'b0);
    access(1'b0, 3'd7, 8'h00, 0, 5, 8'hFF, 1'b0);
    access(1'b0, 3'd0, 8'h00, 0, 5, 8'h00, 1'b0);
    access(1'b0, 3'd5, 8'h00, 0, 5, 8'hAA, 1'b0);

    // Reset in the middle of a read's STROBE phase
    req_we = 1'b0; req_addr = 3'd7; req_valid = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_sel_on", mem_sel, 8'h80);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals("mid");
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    chk("no_rsp_dropped", seen, 0);
    chk("idle_after_drop", req_ready, 1);

`ifdef MEM8X8_READBACK_VERIFY_EN
    corrupt = 1'b1;
    access(1'b1, 3'd3, 8'hF0, 0, 9, 8'hF1, 1'b1);
    corrupt = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
